test_sequencer: RTL

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/test_sequencer.sv
// test_sequencer: loads a program word stream into a ROM, then runs the CPU until it
// raises its end flag (plus a fixed drain period) or a cycle budget runs out.
// Ports: clk/rst; start pulse; ld_* program stream (valid/ready); rom_* ROM write port;
//        cpu_run (CPU reset release); x3/x26/x27 CPU result registers; busy/done/pass/
//        timeout/fail_testnum status.
module test_sequencer #(
  parameter int ADDR_W         = 12,
  parameter int DRAIN_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_run,
  input  logic [31:0]       x3,
  input  logic [31:0]       x26,
  input  logic [31:0]       x27,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       fail_testnum
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  // A zero drain length degenerates to a single drain cycle.
  localparam logic [31:0]       DRN_LAST  = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       cnt;
  logic              accept;
  logic              is_last;
  logic              end_flag;

  assign ld_ready = (state == LOAD);
  assign cpu_run  = (state == RUN) || (state == DRAIN);
  assign busy     = (state == LOAD) || cpu_run;
  assign done     = (state == DONE);

  assign accept   = ld_valid & ld_ready;
  // The top ROM address terminates the load so the address never wraps.
  assign is_last  = accept & (ld_last | (addr == ADDR_MAX));
  assign end_flag = (x26 == 32'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)   state_nxt = LOAD;
      LOAD:       if (is_last) state_nxt = RUN;
      // The end flag wins over a timeout landing in the same cycle.
      RUN: begin
        if (end_flag)             state_nxt = DRAIN;
        else if (cnt == TMO_LAST) state_nxt = DONE;
      end
      DRAIN:      if (cnt == DRN_LAST) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      cnt          <= '0;
      rom_we       <= 1'b0;
      rom_waddr    <= '0;
      rom_wdata    <= '0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else begin
      state  <= state_nxt;
      rom_we <= accept;
      if (accept) begin
        rom_waddr <= addr;
        rom_wdata <= ld_data;
        if (addr != ADDR_MAX) addr <= addr + 1'b1;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass         <= 1'b0;
            timeout      <= 1'b0;
            fail_testnum <= '0;
            addr         <= '0;
            cnt          <= '0;
          end
        end
        RUN: begin
          if (end_flag) begin
            cnt <= '0;
          end else if (cnt == TMO_LAST) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DRAIN: begin
          if (cnt == DRN_LAST) begin
            pass         <= (x27 == 32'd1);
            fail_testnum <= (x27 == 32'd1) ? 32'd0 : x3;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
